// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared definitions for the LSU pipeline stage: default data
//               width, MemOP size/sign encodings and the FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    localparam int XLEN_DEF = 64;

    // MemOP: low two bits give the access size, bit 2 selects zero-extension.
    typedef enum logic [2:0] {
        MOP_B   = 3'b000,
        MOP_H   = 3'b001,
        MOP_W   = 3'b010,
        MOP_D   = 3'b011,
        MOP_BU  = 3'b100,
        MOP_HU  = 3'b101,
        MOP_WU  = 3'b110,
        MOP_RSV = 3'b111
    } memop_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_RSP = 2'd2
    } lsu_state_e;

endpackage
`default_nettype wire

// File: rtl/lsu_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : lsu_stage_if
// Description : Request/response data-bus bundle between the LSU and memory.
//               master : LSU side (drives requests, receives responses)
//               slave  : memory side
// Signals     : mem_req_valid/ready, mem_req_addr, mem_req_wen,
//               mem_req_wdata, mem_req_wmask, mem_rsp_valid, mem_rsp_rdata
// Revision    : 1.0 - initial release
// ============================================================================
interface lsu_stage_if #(
    parameter int XLEN   = lsu_pkg::XLEN_DEF,
    parameter int MASK_W = XLEN / 8
) ();
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [XLEN-1:0]   mem_req_addr;
    logic              mem_req_wen;
    logic [XLEN-1:0]   mem_req_wdata;
    logic [MASK_W-1:0] mem_req_wmask;
    logic              mem_rsp_valid;
    logic [XLEN-1:0]   mem_rsp_rdata;

    modport master (
        output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
    );
endinterface
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Combinational data alignment for the LSU.
//               Store side: shifts store data and builds the byte mask for
//               the byte offset inside the doubleword.
//               Load side : shifts read data down by the offset, then sign-
//               or zero-extends according to MemOP (3'b111 yields zero).
// Ports       : st_off/st_size/st_data -> st_wdata/st_wmask
//               ld_off/ld_op/ld_rdata  -> ld_data
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int MASK_W = XLEN / 8
) (
    input  logic [2:0]        st_off,
    input  logic [1:0]        st_size,
    input  logic [XLEN-1:0]   st_data,
    output logic [XLEN-1:0]   st_wdata,
    output logic [MASK_W-1:0] st_wmask,
    input  logic [2:0]        ld_off,
    input  logic [2:0]        ld_op,
    input  logic [XLEN-1:0]   ld_rdata,
    output logic [XLEN-1:0]   ld_data
);
    logic [MASK_W-1:0] w_base_mask;
    logic [XLEN-1:0]   w_shifted;

    always_comb begin
        case (st_size)
            2'b00:   w_base_mask = MASK_W'(8'h01);
            2'b01:   w_base_mask = MASK_W'(8'h03);
            2'b10:   w_base_mask = MASK_W'(8'h0F);
            default: w_base_mask = '1;
        endcase
    end

    // Bytes shifted past the top of the doubleword are simply dropped, so a
    // crossing access only touches the in-doubleword bytes.
    assign st_wdata  = st_data << {st_off, 3'b000};
    assign st_wmask  = w_base_mask << st_off;
    assign w_shifted = ld_rdata >> {ld_off, 3'b000};

    always_comb begin
        case (ld_op)
            MOP_B:   ld_data = {{(XLEN-8){w_shifted[7]}},   w_shifted[7:0]};
            MOP_H:   ld_data = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
            MOP_W:   ld_data = {{(XLEN-32){w_shifted[31]}}, w_shifted[31:0]};
            MOP_D:   ld_data = w_shifted;
            MOP_BU:  ld_data = {{(XLEN-8){1'b0}},  w_shifted[7:0]};
            MOP_HU:  ld_data = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
            MOP_WU:  ld_data = {{(XLEN-32){1'b0}}, w_shifted[31:0]};
            default: ld_data = '0;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/lsu_stage.sv
`default_nettype none
// ============================================================================
// Module      : lsu_stage
// Description : Memory-access pipeline stage between EXU and WB. Takes one
//               instruction at a time, performs loads/stores over a
//               request/response bus and presents results to WB.
//               Non-memory instructions pass through with one cycle latency.
// Ports       : clk, rst (sync, active high)
//               EXU side : exu_valid/lsu_ready, ex_pc, ex_inst, ALUres,
//                          ex_sdata, MemRd, MemWr, MemOP, ex_Wdata_src, ex_RegWr
//               WB side  : lsu_valid/wb_ready, wb_pc, wb_inst, wb_ALUres,
//                          MemOut, wb_Wdata_src, wb_RegWr
//               mem      : lsu_stage_if.master data bus
// Macro       : LSU_PERF_CNT_EN adds perf_load_cnt, perf_store_cnt and
//               perf_stall_cnt (64-bit, wrapping).
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_stage
    import lsu_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int MASK_W = XLEN / 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            exu_valid,
    output logic            lsu_ready,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [31:0]     ex_inst,
    input  logic [XLEN-1:0] ALUres,
    input  logic [XLEN-1:0] ex_sdata,
    input  logic            MemRd,
    input  logic            MemWr,
    input  logic [2:0]      MemOP,
    input  logic [1:0]      ex_Wdata_src,
    input  logic            ex_RegWr,
    output logic            lsu_valid,
    input  logic            wb_ready,
    output logic [XLEN-1:0] wb_pc,
    output logic [XLEN-1:0] wb_ALUres,
    output logic [XLEN-1:0] MemOut,
    output logic [31:0]     wb_inst,
    output logic [1:0]      wb_Wdata_src,
    output logic            wb_RegWr,
    lsu_stage_if.master     mem
`ifdef LSU_PERF_CNT_EN
    ,
    output logic [63:0]     perf_load_cnt,
    output logic [63:0]     perf_store_cnt,
    output logic [63:0]     perf_stall_cnt
`endif
);
    lsu_state_e        state_q, state_d;
    logic              lsu_valid_q, lsu_valid_d;
    logic [XLEN-1:0]   wb_pc_q, wb_pc_d, wb_alures_q, wb_alures_d, mem_out_q, mem_out_d;
    logic [31:0]       wb_inst_q, wb_inst_d;
    logic [1:0]        wb_wsrc_q, wb_wsrc_d;
    logic              wb_regwr_q, wb_regwr_d;
    logic [2:0]        op_q, op_d;
    logic              req_valid_q, req_valid_d, req_wen_q, req_wen_d;
    logic [XLEN-1:0]   req_addr_q, req_addr_d, req_wdata_q, req_wdata_d;
    logic [MASK_W-1:0] req_wmask_q, req_wmask_d;

    logic [XLEN-1:0]   w_st_wdata, w_ld_data;
    logic [MASK_W-1:0] w_st_wmask;
    logic              w_accept, w_rsp_done;

    assign lsu_ready  = (state_q == ST_IDLE) && (!lsu_valid_q || wb_ready);
    assign w_accept   = exu_valid && lsu_ready;
    assign w_rsp_done = (state_q == ST_WAIT_RSP) && mem.mem_rsp_valid;

    // The WB fields of a memory instruction are captured at accept time, so
    // wb_alures_q still holds the effective address when the response arrives
    // and its low bits double as the load byte offset.
    lsu_align #(.XLEN(XLEN), .MASK_W(MASK_W)) u_align (
        .st_off   (ALUres[2:0]),
        .st_size  (MemOP[1:0]),
        .st_data  (ex_sdata),
        .st_wdata (w_st_wdata),
        .st_wmask (w_st_wmask),
        .ld_off   (wb_alures_q[2:0]),
        .ld_op    (op_q),
        .ld_rdata (mem.mem_rsp_rdata),
        .ld_data  (w_ld_data)
    );

    always_comb begin
        state_d     = state_q;
        lsu_valid_d = lsu_valid_q;
        wb_pc_d     = wb_pc_q;
        wb_alures_d = wb_alures_q;
        mem_out_d   = mem_out_q;
        wb_inst_d   = wb_inst_q;
        wb_wsrc_d   = wb_wsrc_q;
        wb_regwr_d  = wb_regwr_q;
        op_d        = op_q;
        req_valid_d = req_valid_q;
        req_wen_d   = req_wen_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        req_wmask_d = req_wmask_q;

        if (lsu_valid_q && wb_ready) begin
            lsu_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    wb_pc_d     = ex_pc;
                    wb_inst_d   = ex_inst;
                    wb_alures_d = ALUres;
                    wb_wsrc_d   = ex_Wdata_src;
                    wb_regwr_d  = ex_RegWr;
                    op_d        = MemOP;
                    if (MemRd || MemWr) begin
                        // MemWr wins when both are set: the access is a store.
                        req_valid_d = 1'b1;
                        req_wen_d   = MemWr;
                        req_addr_d  = {ALUres[XLEN-1:3], 3'b000};
                        req_wdata_d = MemWr ? w_st_wdata : '0;
                        req_wmask_d = MemWr ? w_st_wmask : '0;
                        state_d     = ST_REQ;
                    end else begin
                        mem_out_d   = '0;
                        lsu_valid_d = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                if (mem.mem_req_ready) begin
                    req_valid_d = 1'b0;
                    state_d     = ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                if (mem.mem_rsp_valid) begin
                    mem_out_d   = req_wen_q ? '0 : w_ld_data;
                    lsu_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            lsu_valid_q <= 1'b0;
            wb_pc_q     <= '0;
            wb_alures_q <= '0;
            mem_out_q   <= '0;
            wb_inst_q   <= '0;
            wb_wsrc_q   <= '0;
            wb_regwr_q  <= 1'b0;
            op_q        <= '0;
            req_valid_q <= 1'b0;
            req_wen_q   <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_wmask_q <= '0;
        end else begin
            state_q     <= state_d;
            lsu_valid_q <= lsu_valid_d;
            wb_pc_q     <= wb_pc_d;
            wb_alures_q <= wb_alures_d;
            mem_out_q   <= mem_out_d;
            wb_inst_q   <= wb_inst_d;
            wb_wsrc_q   <= wb_wsrc_d;
            wb_regwr_q  <= wb_regwr_d;
            op_q        <= op_d;
            req_valid_q <= req_valid_d;
            req_wen_q   <= req_wen_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            req_wmask_q <= req_wmask_d;
        end
    end

    assign lsu_valid         = lsu_valid_q;
    assign wb_pc             = wb_pc_q;
    assign wb_ALUres         = wb_alures_q;
    assign MemOut            = mem_out_q;
    assign wb_inst           = wb_inst_q;
    assign wb_Wdata_src      = wb_wsrc_q;
    assign wb_RegWr          = wb_regwr_q;
    assign mem.mem_req_valid = req_valid_q;
    assign mem.mem_req_addr  = req_addr_q;
    assign mem.mem_req_wen   = req_wen_q;
    assign mem.mem_req_wdata = req_wdata_q;
    assign mem.mem_req_wmask = req_wmask_q;

`ifdef LSU_PERF_CNT_EN
    logic [63:0] perf_load_q, perf_load_d, perf_store_q, perf_store_d, perf_stall_q, perf_stall_d;

    always_comb begin
        perf_load_d  = perf_load_q  + 64'(w_rsp_done && !req_wen_q);
        perf_store_d = perf_store_q + 64'(w_rsp_done && req_wen_q);
        perf_stall_d = perf_stall_q + 64'(state_q != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_load_q  <= '0;
            perf_store_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_load_q  <= perf_load_d;
            perf_store_q <= perf_store_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_load_cnt  = perf_load_q;
    assign perf_store_cnt = perf_store_q;
    assign perf_stall_cnt = perf_stall_q;
`endif
endmodule
`default_nettype wire
